cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle fetch/decode/execute/writeback sequencer for the little-computer CPU core. It owns the program counter and instruction register and runs the instruction-memory request/ready handshake. It issues one-cycle execute and register-write strobes to the datapath, and it latches a permanent halted state when the decoder flags the halt opcode. It sits between instruction memory, the instruction decoder (which reads `ir`) and the ALU/register-file datapath.

## Interface
- `INSTR_WIDTH`, 16, instruction and `ir` width; must equal `InstrWidth` in defs.vh
- `PC_WIDTH`, 16, program counter and memory address width
- `RESET_PC`, 0, PC value loaded on reset
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `run`  in  1  level; start or continue sequencing
- `imem_req`  out  1  instruction fetch request
- `imem_addr`  out  PC_WIDTH  fetch address; equals `pc`
- `imem_ready`  in  1  memory accepts the request and returns data this cycle
- `imem_data`  in  INSTR_WIDTH  instruction word; valid when `imem_ready`=1
- `ir`  out  INSTR_WIDTH  latched instruction, drives the decoder
- `dec_halt`  in  1  decoder: `ir` is the halt opcode
- `dec_reg_write_en`  in  1  decoder: `ir` writes the register file
- `branch_taken`  in  1  datapath: redirect PC; sampled in WRITEBACK only
- `branch_target`  in  PC_WIDTH  redirect address
- `pc`  out  PC_WIDTH  current program counter
- `alu_en`  out  1  one-cycle execute strobe
- `reg_write`  out  1  one-cycle register-file write strobe
- `halted`  out  1  sticky halt indicator
- `retired`  out  16  count of completed non-halt instructions; wraps

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- IDLE: all strobes 0. Goes to FETCH when `run`=1.
- FETCH: `imem_req`=1 and `imem_addr`=`pc`, both held stable until `imem_ready`=1. On the ready cycle `ir`<=`imem_data` and the state goes to DECODE. `imem_ready` is ignored outside FETCH.
- DECODE: one cycle. Goes to HALT if `dec_halt`=1, otherwise to EXECUTE.
- EXECUTE: `alu_en`=1 for exactly this cycle. Goes to WRITEBACK.
- WRITEBACK:
  - `reg_write`=`dec_reg_write_en`.
  - `pc`<=`branch_taken` ? `branch_target` : `pc`+1, computed modulo 2^PC_WIDTH (0xFFFF+1 -> 0x0000).
  - `retired` increments by 1, wrapping 0xFFFF -> 0.
  - Next state is FETCH if `run`=1, else IDLE.
- HALT: `halted`=1. `pc` holds the halt instruction's address and `retired` is not incremented. The block stays in HALT regardless of `run` until `rst_n` is asserted.
- Deasserting `run` mid-instruction does not abort it: the instruction completes through WRITEBACK, then the block parks in IDLE with the updated `pc`.
- Reset: `pc`=RESET_PC, `ir`=0, `retired`=0, state IDLE. `imem_req`, `alu_en`, `reg_write` and `halted` all read 0. Reset during FETCH drops `imem_req` immediately (asynchronously), without waiting for the clock.

## Timing
- Minimum 4 cycles per instruction (FETCH, DECODE, EXECUTE, WRITEBACK) when `imem_ready`=1 on the first FETCH cycle. Each wait cycle on `imem_ready` adds one cycle.
- `ir` is valid from the first DECODE cycle and stays constant until the next FETCH handshake, so decoder outputs are stable through EXECUTE and WRITEBACK.
- `alu_en` and `reg_write` are registered or state-decoded and glitch-free. Each is high for at most one cycle per instruction, and never in the same cycle.
- The new `pc` is visible the cycle after WRITEBACK, i.e. on the next FETCH `imem_addr`.
- `halted` rises the cycle after DECODE sees `dec_halt`=1.
- Back-to-back instructions: FETCH follows WRITEBACK directly, with no idle cycle.

## Test plan
- Reset then `run`=1, memory always ready, three non-halt instructions with `dec_reg_write_en`=1 -> `imem_addr` 0,1,2 on FETCH cycles; `reg_write` pulses on cycles 4, 8, 12 after run; `retired`=3.
- `imem_ready` held low for 5 cycles at address 0 -> `imem_req` and `imem_addr`=0 stable for 6 cycles, `ir` unchanged until the ready cycle; total instruction time 9 cycles.
- `branch_taken`=1, `branch_target`=0x0040 in WRITEBACK of the instruction at 0x0003 -> next `imem_addr`=0x0040. With RESET_PC=0xFFFF and no branch -> second fetch at 0x0000.
- `dec_halt`=1 for the instruction at 0x0002 -> `halted`=1 one cycle after DECODE, no `alu_en`/`reg_write`, `pc`=0x0002, `retired`=2; toggling `run` has no effect.
- `run` dropped during EXECUTE -> WRITEBACK still occurs, `pc` advances by 1, block idles with no `imem_req`. Raising `run` resumes fetch at the new `pc`.
- `rst_n` pulsed low mid-FETCH while waiting on memory -> `imem_req`=0 immediately; after release `pc`=RESET_PC, `retired`=0, state IDLE.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute/writeback sequencer: owns pc and ir, runs the instruction
// fetch handshake, and issues one-cycle execute and register-write strobes.
module cpu_sequencer #(
  parameter int                  INSTR_WIDTH = 16,
  parameter int                  PC_WIDTH    = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ready,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] ir,
  input  logic                   dec_halt,
  input  logic                   dec_reg_write_en,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   alu_en,
  output logic                   reg_write,
  output logic                   halted,
  output logic [15:0]            retired,
  output logic [2:0]             dbg_state
);

  // Fetch handshake: imem_req and imem_addr are held stable while in FETCH; a cycle
  // with imem_req=1 and imem_ready=1 transfers imem_data into ir, and imem_ready
  // is ignored in every other state.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic [PC_WIDTH-1:0]     pc_q, pc_d;
  logic [INSTR_WIDTH-1:0]  ir_q, ir_d;
  logic [15:0]             retired_q, retired_d;

  // State register; the async reset also clears imem_req since it is state-decoded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (run) state_d = ST_FETCH;
      ST_FETCH:     if (imem_ready) state_d = ST_DECODE;
      ST_DECODE:    state_d = dec_halt ? ST_HALT : ST_EXECUTE;
      ST_EXECUTE:   state_d = ST_WRITEBACK;
      ST_WRITEBACK: state_d = run ? ST_FETCH : ST_IDLE;
      ST_HALT:      state_d = ST_HALT;
      default:      state_d = ST_IDLE;
    endcase
  end

  // pc and retired only move in WRITEBACK, so a halted instruction keeps its address.
  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    if (state_q == ST_FETCH && imem_ready) begin
      ir_d = imem_data;
    end
    if (state_q == ST_WRITEBACK) begin
      pc_d      = branch_taken ? branch_target : pc_q + PC_WIDTH'(1);
      retired_d = retired_q + 16'd1;
    end
  end

  always_comb begin
    imem_req  = (state_q == ST_FETCH);
    alu_en    = (state_q == ST_EXECUTE);
    reg_write = (state_q == ST_WRITEBACK) && dec_reg_write_en;
    halted    = (state_q == ST_HALT);
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign retired   = retired_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: expected fetch addresses are queued as each
// scenario is set up and popped when the sequencer issues the matching fetch.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        run2 = 1'b0;
  logic        imem_ready = 1'b0;
  logic [15:0] imem_data = '0;
  logic        dec_halt = 1'b0;
  logic        dec_reg_write_en = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = '0;

  logic        imem_req, alu_en, reg_write, halted;
  logic [15:0] imem_addr, ir, pc, retired;
  logic [2:0]  dbg_state;

  logic        imem_req2, alu_en2, reg_write2, halted2;
  logic [15:0] imem_addr2, ir2, pc2, retired2;
  logic [2:0]  dbg_state2;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int unsigned t0, last_wb, fetch_cyc;
  int          m_ret = 0;
  logic [15:0] m_ir = '0;
  logic [15:0] exp_q[$];

  cpu_sequencer #(.INSTR_WIDTH(16), .PC_WIDTH(16), .RESET_PC(16'h0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_data(imem_data), .ir(ir), .dec_halt(dec_halt),
    .dec_reg_write_en(dec_reg_write_en), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc(pc), .alu_en(alu_en),
    .reg_write(reg_write), .halted(halted), .retired(retired),
    .dbg_state(dbg_state)
  );

  cpu_sequencer #(.INSTR_WIDTH(16), .PC_WIDTH(16), .RESET_PC(16'hFFFF)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .run(run2),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ready(imem_ready),
    .imem_data(imem_data), .ir(ir2), .dec_halt(dec_halt),
    .dec_reg_write_en(dec_reg_write_en), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc(pc2), .alu_en(alu_en2),
    .reg_write(reg_write2), .halted(halted2), .retired(retired2),
    .dbg_state(dbg_state2)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0] ^ 8'h5A, ~a[7:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fetch(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // driver: runs one instruction from its FETCH through WRITEBACK (or HALT)
  task automatic do_instr(input int waits, input bit halt, input bit rwe,
                          input bit br, input logic [15:0] tgt, input bit drop_run);
    logic [15:0] a;
    bit ok;
    wait_fetch(ok);
    check("fetch_seen", {31'd0, ok}, 1);
    if (!ok) return;
    check("exp_q_has_entry", {31'd0, exp_q.size() != 0}, 1);
    a = exp_q.pop_front();
    fetch_cyc = cyc;
    for (int i = 0; i <= waits; i++) begin
      check("imem_req", {31'd0, imem_req}, 1);
      check("imem_addr", {16'd0, imem_addr}, {16'd0, a});
      check("ir_hold", {16'd0, ir}, {16'd0, m_ir});
      imem_data  = mem_word(a);
      imem_ready = (i == waits);
      @(negedge clk);
    end
    imem_ready = 1'b0;
    imem_data  = 16'hDEAD;
    m_ir = mem_word(a);
    check("dec_ir", {16'd0, ir}, {16'd0, m_ir});
    check("dec_alu_en", {31'd0, alu_en}, 0);
    check("dec_reg_write", {31'd0, reg_write}, 0);
    check("dec_halted", {31'd0, halted}, 0);
    check("dec_imem_req", {31'd0, imem_req}, 0);
    dec_halt = halt;
    dec_reg_write_en = rwe;
    @(negedge clk);
    if (halt) begin
      check("halt_halted", {31'd0, halted}, 1);
      check("halt_alu_en", {31'd0, alu_en}, 0);
      check("halt_reg_write", {31'd0, reg_write}, 0);
      check("halt_pc", {16'd0, pc}, {16'd0, a});
      dec_halt = 1'b0;
      dec_reg_write_en = 1'b0;
      return;
    end
    check("ex_alu_en", {31'd0, alu_en}, 1);
    check("ex_reg_write", {31'd0, reg_write}, 0);
    check("ex_pc", {16'd0, pc}, {16'd0, a});
    if (drop_run) run = 1'b0;
    branch_taken  = br;
    branch_target = tgt;
    @(negedge clk);
    check("wb_reg_write", {31'd0, reg_write}, {31'd0, rwe});
    check("wb_alu_en", {31'd0, alu_en}, 0);
    check("wb_ir", {16'd0, ir}, {16'd0, m_ir});
    last_wb = cyc;
    @(negedge clk);
    branch_taken = 1'b0;
    dec_reg_write_en = 1'b0;
    m_ret++;
    check("retired", {16'd0, retired}, m_ret);
    check("next_pc", {16'd0, pc}, {16'd0, br ? tgt : a + 16'd1});
  endtask

  initial begin
    logic [15:0] a;
    bit ok;
    // reset state
    repeat (2) @(negedge clk);
    check("rst_pc", {16'd0, pc}, 0);
    check("rst_ir", {16'd0, ir}, 0);
    check("rst_retired", {16'd0, retired}, 0);
    check("rst_imem_req", {31'd0, imem_req}, 0);
    check("rst_alu_en", {31'd0, alu_en}, 0);
    check("rst_reg_write", {31'd0, reg_write}, 0);
    check("rst_halted", {31'd0, halted}, 0);
    check("rst_pc2", {16'd0, pc2}, 32'h0000FFFF);
    rst_n = 1'b1;
    @(negedge clk);

    // RESET_PC=0xFFFF: pc wraps to 0x0000 on the second fetch
    run2 = 1'b1;
    imem_ready = 1'b1;
    imem_data = 16'h1234;
    @(negedge clk);
    check("wrap_req1", {31'd0, imem_req2}, 1);
    check("wrap_addr1", {16'd0, imem_addr2}, 32'h0000FFFF);
    repeat (4) @(negedge clk);
    check("wrap_req2", {31'd0, imem_req2}, 1);
    check("wrap_addr2", {16'd0, imem_addr2}, 0);
    run2 = 1'b0;
    repeat (5) @(negedge clk);
    check("wrap_idle", {29'd0, dbg_state2}, 0);
    check("wrap_pc_after", {16'd0, pc2}, 1);
    check("wrap_retired", {16'd0, retired2}, 2);
    check("dut1_still_idle", {31'd0, imem_req}, 0);
    imem_ready = 1'b0;
    @(negedge clk);

    // three back-to-back instructions, memory always ready
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0002);
    run = 1'b1;
    t0 = cyc;
    do_instr(0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    check("wb_cycle_1", last_wb - t0, 4);
    do_instr(0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    check("wb_cycle_2", last_wb - t0, 8);
    do_instr(0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    check("wb_cycle_3", last_wb - t0, 12);
    check("retired_3", {16'd0, retired}, 3);

    // five memory wait cycles, then a taken branch to 0x0040
    exp_q.push_back(16'h0003);
    exp_q.push_back(16'h0040);
    do_instr(5, 1'b0, 1'b1, 1'b1, 16'h0040, 1'b0);
    check("instr_time_wait5", last_wb - fetch_cyc + 1, 9);

    // run dropped during EXECUTE: instruction completes and parks in IDLE
    do_instr(0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    check("drop_idle_state", {29'd0, dbg_state}, 0);
    check("drop_pc", {16'd0, pc}, 32'h41);
    repeat (3) begin
      @(negedge clk);
      check("drop_no_req", {31'd0, imem_req}, 0);
    end
    exp_q.push_back(16'h0041);
    exp_q.push_back(16'h0042);
    run = 1'b1;
    do_instr(0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);

    // reset pulsed while waiting on memory in FETCH
    wait_fetch(ok);
    check("rstf_fetch_seen", {31'd0, ok}, 1);
    a = exp_q.pop_front();
    check("rstf_addr", {16'd0, imem_addr}, {16'd0, a});
    imem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rstf_req_before", {31'd0, imem_req}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstf_req_async", {31'd0, imem_req}, 0);
    check("rstf_pc_async", {16'd0, pc}, 0);
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ret = 0;
    m_ir = '0;
    check("rstf_state", {29'd0, dbg_state}, 0);
    check("rstf_retired", {16'd0, retired}, 0);
    check("rstf_ir", {16'd0, ir}, 0);
    @(negedge clk);
    check("rstf_idle_req", {31'd0, imem_req}, 0);

    // halt on the instruction at 0x0002
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0002);
    run = 1'b1;
    do_instr(0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    do_instr(0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    do_instr(0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    check("halt_retired", {16'd0, retired}, 2);
    run = 1'b0;
    repeat (3) @(negedge clk);
    run = 1'b1;
    imem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("halt_sticky", {31'd0, halted}, 1);
      check("halt_no_req", {31'd0, imem_req}, 0);
      check("halt_no_alu", {31'd0, alu_en}, 0);
    end
    check("halt_state", {29'd0, dbg_state}, 5);
    check("halt_pc_hold", {16'd0, pc}, 2);
    check("halt_retired_hold", {16'd0, retired}, 2);
    check("exp_q_drained", exp_q.size(), 0);

    // report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
